// File: rtl/child_seq_pkg.sv
// Shared types and helpers for the child launch sequencer.
package child_seq_pkg;

    localparam int NUM_CHILD_DEF = 5;
    localparam int MAX_CHILD     = 16;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        LAUNCH,
        WAIT,
        FINISH,
        FINISH_ERR
    } seq_state_e;

    // Lowest enabled index >= start among the first num children; num when none.
    function automatic logic [4:0] next_en_idx(
        input logic [MAX_CHILD-1:0] mask,
        input logic [4:0]           start,
        input int                   num
    );
        next_en_idx = 5'(num);
        for (int i = MAX_CHILD - 1; i >= 0; i--) begin
            if (i < num && i >= int'(start) && mask[i]) begin
                next_en_idx = 5'(i);
            end
        end
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter for the sequencer; cleared at launch, counts WAIT cycles, saturates at TIMEOUT_CYC.
module seq_wait_timer #(
    parameter int TIMEOUT_CYC = 255,
    localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/child_launch_sequencer.sv
// Starts enabled children in index order and waits for each done before the next.
// Define SEQ_TIMEOUT_EN to build the per-child wait timeout (error / err_idx / FINISH_ERR).
//
// state      | meaning
// IDLE       | no run; go latches mask and clears error
// SCAN       | step idx one per cycle until an enabled child or the end
// LAUNCH     | one-cycle start pulse to child idx
// WAIT       | wait for child_done[idx]
// FINISH     | run_done pulse
// FINISH_ERR | timed-out run ends without run_done
module child_launch_sequencer
    import child_seq_pkg::*;
#(
    parameter int NUM_CHILD   = NUM_CHILD_DEF,
    parameter int IDX_W       = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [NUM_CHILD-1:0] child_mask,
    output logic [NUM_CHILD-1:0] child_start,
    input  logic [NUM_CHILD-1:0] child_done,
    output logic                 busy,
    output logic                 run_done,
    output logic                 error,
    output logic [IDX_W-1:0]     cur_idx,
    output logic [IDX_W-1:0]     err_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

    seq_state_e           state_q, state_d;
    logic [NUM_CHILD-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     err_idx_q, err_idx_d;
    logic                 error_q, error_d;
    logic                 tmo_hit;
    logic                 mask_empty;

    assign mask_empty = (next_en_idx(MAX_CHILD'(mask_q), 5'd0, NUM_CHILD) == 5'(NUM_CHILD));

`ifdef SEQ_TIMEOUT_EN
    logic tmr_clr, tmr_inc;

    assign tmr_clr = (state_q == LAUNCH);
    assign tmr_inc = (state_q == WAIT);

    seq_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmo_hit)
    );
`else
    assign tmo_hit = 1'b0;

    // TIMEOUT_CYC has no effect without the wait timer.
    if (TIMEOUT_CYC < 1) begin : g_tmo_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        error_d     = error_q;
        err_idx_d   = err_idx_q;
        child_start = '0;
        run_done    = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        mask_d  = child_mask;
                        error_d = 1'b0;
                        idx_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (mask_empty) begin
                        state_d = FINISH;
                    end else if (mask_q[idx_q]) begin
                        state_d = LAUNCH;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                LAUNCH: begin
                    child_start[idx_q] = 1'b1;
                    state_d            = WAIT;
                end
                WAIT: begin
                    // A done in the terminal-count cycle still counts as success.
                    if (child_done[idx_q]) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = FINISH;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = SCAN;
                        end
                    end else if (tmo_hit) begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = FINISH_ERR;
                    end
                end
                FINISH: begin
                    run_done = 1'b1;
                    state_d  = IDLE;
                end
                FINISH_ERR: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            idx_q     <= '0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign error   = error_q;
    assign cur_idx = idx_q;
    assign err_idx = err_idx_q;

endmodule

// File: doc/child_launch_sequencer.md
Name: child_launch_sequencer

Overview:
Sequences the five sibling sub-instances of a root module. It starts each enabled child in index order with a one-cycle start pulse, then waits for that child's done before moving to the next child. It reports overall completion, the active child index and per-run errors. It sits beside the child instances in the root module and is the only source of their start strobes.

Parameters:
NUM_CHILD, 5, number of sequenced children (1..16)
IDX_W, $clog2(NUM_CHILD) min 1, width of index outputs
TIMEOUT_CYC, 255, max wait cycles for a child done (used only with SEQ_TIMEOUT_EN)

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
go  input  1  start a run; sampled only in IDLE
abort  input  1  cancel the run in progress; return to IDLE
child_mask  input  NUM_CHILD  1 = child enabled; sampled at go, held for the run
child_start  output  NUM_CHILD  one-hot, one-cycle start pulse to child i
child_done  input  NUM_CHILD  child i done level/pulse; only the active bit is observed
busy  output  1  high from the cycle after go until return to IDLE
run_done  output  1  one-cycle pulse when the run completes without error
error  output  1  sticky; set on timeout, cleared by the next go
cur_idx  output  IDX_W  index of the child being launched or awaited
err_idx  output  IDX_W  index of the child that timed out

Behaviour:
- Reset (async assert, sync release): state = IDLE. child_start=0, busy=0, run_done=0, error=0, cur_idx=0, err_idx=0, latched mask=0.
- IDLE:
  - go=1 latches child_mask and clears error.
  - Next state: SCAN at idx 0.
  - If the latched mask is all zero, go to FINISH directly. busy rises next cycle for one cycle, then run_done pulses.
- SCAN: advance idx to the next enabled child at or after the current idx, at one index per cycle. Reaching an enabled child goes to LAUNCH. Passing NUM_CHILD-1 with none found goes to FINISH.
- LAUNCH: child_start[idx]=1 for exactly this one cycle. Next state: WAIT.
- WAIT:
  - Hold until child_done[idx]=1, then idx+1 and SCAN.
  - If idx = NUM_CHILD-1 when done arrives, go to FINISH.
  - child_done is ignored during LAUNCH, so done asserted in the launch cycle itself is not accepted. The earliest accepted done is the first WAIT cycle.
- FINISH: run_done=1 for one cycle, then IDLE. busy drops on entry to IDLE.
- Latency:
  - go to first child_start: 2 cycles when child 0 is enabled (go→SCAN→LAUNCH).
  - Each done to the next start: 2 cycles plus one cycle per skipped masked child.
- Done bits of non-active children are ignored.
- go while busy is ignored.
- abort has priority over every transition except reset:
  - From any non-IDLE state it goes to IDLE next cycle.
  - No run_done is produced and error is unchanged.
  - A child_start pulse due in that same cycle is suppressed.
- go and abort together in IDLE: abort wins and no run starts.
- cur_idx is registered and equals the internal idx. It holds its last value in IDLE.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- When defined:
  - A wait counter of width $clog2(TIMEOUT_CYC+1) clears on LAUNCH and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without done, error=1, err_idx=idx, and the state goes to FINISH_ERR (one cycle, no run_done), then IDLE.
  - A done arriving in the same cycle the counter reaches TIMEOUT_CYC takes priority: no error.
- When undefined: no counter, WAIT is unbounded, and error and err_idx stay 0.

Decomposition:
- Package child_seq_pkg holds:
  - the state enum (IDLE, SCAN, LAUNCH, WAIT, FINISH, FINISH_ERR)
  - the default NUM_CHILD = 5
  - a function computing the next enabled index from a mask and start index
- One natural sub-module: seq_wait_timer, the wait counter, instantiated only under SEQ_TIMEOUT_EN.

Test Plan:
- mask=5'b11111, each child returns done 3 cycles after its start → starts at 0..4 in order, run_done pulses once, busy spans the run, error=0.
- mask=5'b10010 → only child_start[1] and child_start[4] pulse; child 1 to child 4 gap includes 2 skip cycles; run_done after done[4].
- mask=0 with go → run_done 2 cycles after go, no child_start pulses.
- abort asserted 1 cycle after start[2] → IDLE next cycle, no run_done, no further starts; a later go restarts at child 0.
- SEQ_TIMEOUT_EN, TIMEOUT_CYC=8, child 3 never done → error=1, err_idx=3, no run_done, busy low after FINISH_ERR; the next go clears error.
- Stray done[4] while waiting on child 1, plus go pulses while busy → both ignored, sequence unchanged.
